// File: rtl/pgm_rd_pkg.sv
// Shared definitions for the pgm read-out stage: beat tags, FSM states and
// a small tag helper.
package pgm_rd_pkg;

  localparam logic [1:0] PKT_HEAD = 2'b01;
  localparam logic [1:0] PKT_BODY = 2'b11;
  localparam logic [1:0] PKT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DISCARD,
    ST_EOP
  } rd_state_e;

  function automatic logic is_tail(input logic [133:0] beat);
    return beat[133:132] == PKT_TAIL;
  endfunction

endpackage

// File: rtl/rd_sync_fifo.sv
// Single-clock show-ahead FIFO.
//  clk, rst_n : clock, asynchronous active-low reset
//  wr_en/wr_data : write port; a write to a full FIFO is discarded
//  rd_en/rd_data : read port; rd_data always shows the head entry
//  used       : number of stored entries
//  empty      : no entries stored
//  wr_drop    : combinational, a write was discarded this cycle
module rd_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     used,
  output logic                       empty,
  output logic                       wr_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             full, wr_ok, rd_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign wr_drop = wr_en && full;
  assign used    = cnt;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pgm_rd.sv
// Packet read-out stage behind pgm. Buffers PHVs, 134-bit beats and the
// per-packet keep/drop verdict; forwards kept packets to GOE as one
// unbroken burst (PHV with the first beat, end-of-packet strobe one cycle
// after the last beat) and silently drains dropped ones.
//  in_rd_phv*/in_rd_data*/in_rd_valid* : write side from pgm
//  out_rd_phv_alf/out_rd_alf           : registered almost-full to pgm
//  out_rd_phv*/out_rd_data*/out_rd_valid* : burst to GOE
//  in_rd_phv_alf/in_rd_alf             : GOE back-pressure
//  out_rd_pkt_cnt/out_rd_drop_cnt      : forwarded/discarded packet counts
//  out_rd_ovf                          : sticky FIFO-overflow flag
module pgm_rd
  import pgm_rd_pkg::*;
#(
  parameter int unsigned DATA_DEPTH  = 256,
  parameter int unsigned PKT_DEPTH   = 16,
  parameter int unsigned MAX_PKT_WDS = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] in_rd_phv,
  input  logic          in_rd_phv_wr,
  output logic          out_rd_phv_alf,
  input  logic [133:0]  in_rd_data,
  input  logic          in_rd_data_wr,
  input  logic          in_rd_valid,
  input  logic          in_rd_valid_wr,
  output logic          out_rd_alf,
  output logic [1023:0] out_rd_phv,
  output logic          out_rd_phv_wr,
  input  logic          in_rd_phv_alf,
  output logic [133:0]  out_rd_data,
  output logic          out_rd_data_wr,
  output logic          out_rd_valid,
  output logic          out_rd_valid_wr,
  input  logic          in_rd_alf,
  output logic [31:0]   out_rd_pkt_cnt,
  output logic [31:0]   out_rd_drop_cnt,
  output logic          out_rd_ovf
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned PAW = $clog2(PKT_DEPTH);
  localparam logic [DAW:0] DATA_ALF_TH = (DAW+1)'(DATA_DEPTH - 2*MAX_PKT_WDS);
  localparam logic [PAW:0] PHV_ALF_TH  = (PAW+1)'(PKT_DEPTH - 2);

  rd_state_e state, state_d;

  logic [133:0]  dat_head;
  logic [1023:0] phv_head;
  logic          vld_head;
  logic [DAW:0]  dat_used;
  logic [PAW:0]  phv_used;
  logic [PAW:0]  unused_vld_used;
  logic          dat_empty, phv_empty, vld_empty;
  logic          dat_drop, phv_drop, vld_drop;
  logic          dat_pop, phv_pop, vld_pop;
  logic          phv_wr_d, dat_wr_d, vwr_d, drop_inc;

  rd_sync_fifo #(.WIDTH(134), .DEPTH(DATA_DEPTH)) u_dat_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(in_rd_data_wr), .wr_data(in_rd_data),
    .rd_en(dat_pop), .rd_data(dat_head),
    .used(dat_used), .empty(dat_empty), .wr_drop(dat_drop)
  );

  rd_sync_fifo #(.WIDTH(1024), .DEPTH(PKT_DEPTH)) u_phv_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(in_rd_phv_wr), .wr_data(in_rd_phv),
    .rd_en(phv_pop), .rd_data(phv_head),
    .used(phv_used), .empty(phv_empty), .wr_drop(phv_drop)
  );

  rd_sync_fifo #(.WIDTH(1), .DEPTH(PKT_DEPTH)) u_vld_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(in_rd_valid_wr), .wr_data(in_rd_valid),
    .rd_en(vld_pop), .rd_data(vld_head),
    .used(unused_vld_used), .empty(vld_empty), .wr_drop(vld_drop)
  );

  // The first beat is popped in IDLE alongside the PHV so both leave on the
  // same cycle; ST_EOP is the single gap cycle carrying the verdict strobe.
  always_comb begin
    state_d  = state;
    dat_pop  = 1'b0;
    phv_pop  = 1'b0;
    vld_pop  = 1'b0;
    phv_wr_d = 1'b0;
    dat_wr_d = 1'b0;
    vwr_d    = 1'b0;
    drop_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!phv_empty && !vld_empty) begin
          if (vld_head) begin
            if (!in_rd_alf && !in_rd_phv_alf && !dat_empty) begin
              phv_pop  = 1'b1;
              vld_pop  = 1'b1;
              dat_pop  = 1'b1;
              phv_wr_d = 1'b1;
              dat_wr_d = 1'b1;
              state_d  = is_tail(dat_head) ? ST_EOP : ST_SEND;
            end
          end else begin
            phv_pop = 1'b1;
            vld_pop = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_SEND: begin
        if (!dat_empty) begin
          dat_pop  = 1'b1;
          dat_wr_d = 1'b1;
          if (is_tail(dat_head)) state_d = ST_EOP;
        end
      end
      ST_DISCARD: begin
        if (!dat_empty) begin
          dat_pop = 1'b1;
          if (is_tail(dat_head)) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_EOP: begin
        vwr_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      out_rd_phv      <= '0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_data     <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
      out_rd_pkt_cnt  <= '0;
      out_rd_drop_cnt <= '0;
      out_rd_ovf      <= 1'b0;
      out_rd_alf      <= 1'b0;
      out_rd_phv_alf  <= 1'b0;
    end else begin
      state           <= state_d;
      out_rd_phv_wr   <= phv_wr_d;
      out_rd_data_wr  <= dat_wr_d;
      out_rd_valid    <= vwr_d;
      out_rd_valid_wr <= vwr_d;
      if (phv_wr_d) out_rd_phv  <= phv_head;
      if (dat_wr_d) out_rd_data <= dat_head;
      if (vwr_d)    out_rd_pkt_cnt  <= out_rd_pkt_cnt + 32'd1;
      if (drop_inc) out_rd_drop_cnt <= out_rd_drop_cnt + 32'd1;
      out_rd_ovf     <= out_rd_ovf | dat_drop | phv_drop | vld_drop;
      out_rd_alf     <= (dat_used >= DATA_ALF_TH);
      out_rd_phv_alf <= (phv_used >= PHV_ALF_TH);
    end
  end

endmodule

// File: tb/tb_pgm_rd.sv
module tb_pgm_rd;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1023:0] in_rd_phv = '0;
  logic          in_rd_phv_wr = 1'b0;
  logic          out_rd_phv_alf;
  logic [133:0]  in_rd_data = '0;
  logic          in_rd_data_wr = 1'b0;
  logic          in_rd_valid = 1'b0;
  logic          in_rd_valid_wr = 1'b0;
  logic          out_rd_alf;
  logic [1023:0] out_rd_phv;
  logic          out_rd_phv_wr;
  logic          in_rd_phv_alf = 1'b0;
  logic [133:0]  out_rd_data;
  logic          out_rd_data_wr;
  logic          out_rd_valid;
  logic          out_rd_valid_wr;
  logic          in_rd_alf = 1'b0;
  logic [31:0]   out_rd_pkt_cnt;
  logic [31:0]   out_rd_drop_cnt;
  logic          out_rd_ovf;

  pgm_rd #(.DATA_DEPTH(256), .PKT_DEPTH(16), .MAX_PKT_WDS(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr), .out_rd_phv_alf(out_rd_phv_alf),
    .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
    .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr), .out_rd_alf(out_rd_alf),
    .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr), .in_rd_phv_alf(in_rd_phv_alf),
    .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
    .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr), .in_rd_alf(in_rd_alf),
    .out_rd_pkt_cnt(out_rd_pkt_cnt), .out_rd_drop_cnt(out_rd_drop_cnt), .out_rd_ovf(out_rd_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture, sampled on the falling edge.
  logic [1023:0] phv_q[$];
  logic [133:0]  dat_q[$];
  int            phv_t[$], dat_t[$], vwr_t[$];
  logic          vwr_v[$];

  always @(negedge clk) begin
    if (out_rd_phv_wr)   begin phv_q.push_back(out_rd_phv);  phv_t.push_back(cyc); end
    if (out_rd_data_wr)  begin dat_q.push_back(out_rd_data); dat_t.push_back(cyc); end
    if (out_rd_valid_wr) begin vwr_v.push_back(out_rd_valid); vwr_t.push_back(cyc); end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] mk_phv(input int unsigned seed);
    logic [31:0] w;
    w = seed;
    return (seed == 0) ? 1024'd1 : {32{w}};
  endfunction

  function automatic logic [133:0] mk_beat(input int unsigned seed, input int unsigned i,
                                           input int unsigned n);
    logic [31:0] w;
    logic [1:0]  tag;
    w   = seed * 1000 + i;
    tag = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
    return {tag, {4{w}}, 4'hA};
  endfunction

  task automatic clr_mon();
    phv_q.delete(); dat_q.delete(); phv_t.delete(); dat_t.delete();
    vwr_t.delete(); vwr_v.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_beat(input logic [133:0] b, input logic first, input int unsigned seed);
    @(posedge clk); #1;
    in_rd_data    = b;
    in_rd_data_wr = 1'b1;
    in_rd_phv_wr  = first;
    in_rd_phv     = mk_phv(seed);
    @(posedge clk); #1;
    in_rd_data_wr = 1'b0;
    in_rd_phv_wr  = 1'b0;
  endtask

  // Beats back-to-back, verdict on the cycle after the last beat.
  task automatic send_pkt(input int unsigned nb, input logic keep, input int unsigned seed,
                          output int vcyc);
    for (int unsigned i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      in_rd_data    = mk_beat(seed, i, nb);
      in_rd_data_wr = 1'b1;
      in_rd_phv_wr  = (i == 0);
      in_rd_phv     = mk_phv(seed);
    end
    @(posedge clk); #1;
    in_rd_data_wr  = 1'b0;
    in_rd_phv_wr   = 1'b0;
    in_rd_valid    = keep;
    in_rd_valid_wr = 1'b1;
    vcyc = cyc;
    @(posedge clk); #1;
    in_rd_valid_wr = 1'b0;
  endtask

  // Compare captured output against one expected burst starting at index k.
  task automatic chk_burst(input string nm, input int unsigned k, input int unsigned nb,
                           input int unsigned seed);
    chk({nm, "_phv"}, phv_q[k] == mk_phv(seed), 1'b1);
    chk({nm, "_vld"}, vwr_v[k], 1'b1);
    for (int unsigned i = 0; i < nb; i++)
      chk({nm, "_beat"}, dat_q[k*0 + i], mk_beat(seed, i, nb));
  endtask

  typedef struct {
    int unsigned nb;
    logic        keep;
    int unsigned seed;
    logic        exp_fwd;
    int unsigned exp_pkt;
    int unsigned exp_drop;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int vcyc;
    int unsigned base;

    tbl[0] = '{nb: 4, keep: 1'b1, seed: 0,  exp_fwd: 1'b1, exp_pkt: 1, exp_drop: 0};
    tbl[1] = '{nb: 4, keep: 1'b0, seed: 0,  exp_fwd: 1'b0, exp_pkt: 1, exp_drop: 1};
    tbl[2] = '{nb: 4, keep: 1'b1, seed: 3,  exp_fwd: 1'b1, exp_pkt: 2, exp_drop: 1};
    tbl[3] = '{nb: 7, keep: 1'b0, seed: 4,  exp_fwd: 1'b0, exp_pkt: 2, exp_drop: 2};
    tbl[4] = '{nb: 3, keep: 1'b1, seed: 5,  exp_fwd: 1'b1, exp_pkt: 3, exp_drop: 2};
    tbl[5] = '{nb: 2, keep: 1'b1, seed: 6,  exp_fwd: 1'b1, exp_pkt: 4, exp_drop: 2};

    // Reset state
    idle(3);
    chk("rst_phv_wr",  out_rd_phv_wr, 1'b0);
    chk("rst_data_wr", out_rd_data_wr, 1'b0);
    chk("rst_vwr",     out_rd_valid_wr, 1'b0);
    chk("rst_data",    out_rd_data, '0);
    chk("rst_pkt_cnt", out_rd_pkt_cnt, 0);
    chk("rst_ovf",     out_rd_ovf, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Table-driven packets, GOE open
    for (int unsigned v = 0; v < 6; v++) begin
      clr_mon();
      send_pkt(tbl[v].nb, tbl[v].keep, tbl[v].seed, vcyc);
      idle(tbl[v].nb + 8);
      chk("tbl_phv_n", phv_q.size(), tbl[v].exp_fwd ? 1 : 0);
      chk("tbl_dat_n", dat_q.size(), tbl[v].exp_fwd ? tbl[v].nb : 0);
      chk("tbl_vwr_n", vwr_t.size(), tbl[v].exp_fwd ? 1 : 0);
      if (tbl[v].exp_fwd && phv_q.size() == 1 && dat_q.size() == tbl[v].nb
          && vwr_t.size() == 1) begin
        chk_burst("tbl", 0, tbl[v].nb, tbl[v].seed);
        chk("tbl_t_phv",   phv_t[0], vcyc + 2);
        chk("tbl_t_first", dat_t[0], vcyc + 2);
        chk("tbl_t_last",  dat_t[tbl[v].nb-1], vcyc + 1 + tbl[v].nb);
        chk("tbl_t_vwr",   vwr_t[0], vcyc + 2 + tbl[v].nb);
      end
      chk("tbl_pkt_cnt",  out_rd_pkt_cnt, tbl[v].exp_pkt);
      chk("tbl_drop_cnt", out_rd_drop_cnt, tbl[v].exp_drop);
    end

    // GOE data almost full: hold three packets, then release
    clr_mon();
    in_rd_alf = 1'b1;
    for (int unsigned p = 0; p < 3; p++) send_pkt(4, 1'b1, 10 + p, vcyc);
    idle(10);
    chk("hold_none", phv_q.size() + dat_q.size() + vwr_t.size(), 0);
    chk("hold_phv_alf", out_rd_phv_alf, 1'b0);
    in_rd_alf = 1'b0;
    idle(30);
    chk("rel_phv_n", phv_q.size(), 3);
    chk("rel_dat_n", dat_q.size(), 12);
    chk("rel_vwr_n", vwr_t.size(), 3);
    if (phv_q.size() == 3 && dat_q.size() == 12 && vwr_t.size() == 3) begin
      for (int unsigned p = 0; p < 3; p++) begin
        chk("rel_phv", phv_q[p] == mk_phv(10 + p), 1'b1);
        for (int unsigned i = 0; i < 4; i++)
          chk("rel_beat", dat_q[p*4 + i], mk_beat(10 + p, i, 4));
        chk("rel_vwr_t", vwr_t[p], dat_t[p*4 + 3] + 1);
      end
      chk("rel_gap0", phv_t[1], vwr_t[0] + 1);
      chk("rel_gap1", phv_t[2], vwr_t[1] + 1);
    end
    chk("rel_pkt_cnt", out_rd_pkt_cnt, 7);

    // Data almost-full threshold: 256 - 2*24 = 208 words
    clr_mon();
    for (int unsigned i = 0; i < 207; i++) begin
      @(posedge clk); #1;
      in_rd_data    = mk_beat(70, i, 208);
      in_rd_data_wr = 1'b1;
      in_rd_phv_wr  = (i == 0);
      in_rd_phv     = mk_phv(70);
    end
    @(posedge clk); #1;
    in_rd_data_wr = 1'b0;
    in_rd_phv_wr  = 1'b0;
    idle(2);
    chk("alf_207", out_rd_alf, 1'b0);
    wr_beat(mk_beat(70, 207, 208), 1'b0, 70);
    idle(1);
    chk("alf_208", out_rd_alf, 1'b1);
    @(posedge clk); #1;
    in_rd_valid    = 1'b0;
    in_rd_valid_wr = 1'b1;
    @(posedge clk); #1;
    in_rd_valid_wr = 1'b0;
    idle(230);
    chk("alf_drained", out_rd_alf, 1'b0);
    chk("alf_drop_cnt", out_rd_drop_cnt, 3);
    chk("alf_no_out", phv_q.size() + dat_q.size() + vwr_t.size(), 0);
    chk("alf_ovf", out_rd_ovf, 1'b0);

    // PHV FIFO almost full and overflow with GOE PHV path blocked
    clr_mon();
    in_rd_phv_alf = 1'b1;
    for (int unsigned p = 0; p < 13; p++) send_pkt(2, 1'b1, 20 + p, vcyc);
    idle(3);
    chk("palf_13", out_rd_phv_alf, 1'b0);
    send_pkt(2, 1'b1, 33, vcyc);
    idle(3);
    chk("palf_14", out_rd_phv_alf, 1'b1);
    send_pkt(2, 1'b1, 34, vcyc);
    send_pkt(2, 1'b1, 35, vcyc);
    idle(3);
    chk("ovf_16", out_rd_ovf, 1'b0);
    send_pkt(2, 1'b1, 36, vcyc);
    idle(3);
    chk("ovf_17", out_rd_ovf, 1'b1);
    chk("blk_none", phv_q.size(), 0);
    in_rd_phv_alf = 1'b0;
    idle(80);
    chk("blk_phv_n", phv_q.size(), 16);
    chk("blk_dat_n", dat_q.size(), 32);
    if (phv_q.size() == 16) begin
      base = 20;
      chk("blk_phv_first", phv_q[0] == mk_phv(base), 1'b1);
      chk("blk_phv_last", phv_q[15] == mk_phv(base + 15), 1'b1);
    end
    chk("blk_pkt_cnt", out_rd_pkt_cnt, 23);
    chk("ovf_sticky", out_rd_ovf, 1'b1);
    chk("blk_palf_clr", out_rd_phv_alf, 1'b0);

    // Clean reset, then reset in the middle of a burst
    rst_n = 1'b0;
    idle(2);
    chk("rst2_ovf", out_rd_ovf, 1'b0);
    chk("rst2_pkt_cnt", out_rd_pkt_cnt, 0);
    chk("rst2_drop_cnt", out_rd_drop_cnt, 0);
    rst_n = 1'b1;
    idle(2);
    clr_mon();
    send_pkt(4, 1'b1, 50, vcyc);
    for (int i = 0; i < 40 && dat_q.size() < 2; i++) @(posedge clk);
    chk("mid_wait", dat_q.size() >= 2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_data_wr", out_rd_data_wr, 1'b0);
    chk("mid_phv_wr", out_rd_phv_wr, 1'b0);
    chk("mid_data", out_rd_data, '0);
    chk("mid_phv", out_rd_phv == '0, 1'b1);
    chk("mid_vwr", out_rd_valid_wr, 1'b0);
    idle(3);
    rst_n = 1'b1;
    clr_mon();
    idle(20);
    chk("post_rst_quiet", phv_q.size() + dat_q.size() + vwr_t.size(), 0);
    send_pkt(4, 1'b1, 60, vcyc);
    idle(12);
    chk("post_dat_n", dat_q.size(), 4);
    chk("post_phv_n", phv_q.size(), 1);
    chk("post_vwr_n", vwr_t.size(), 1);
    if (dat_q.size() == 4 && phv_q.size() == 1 && vwr_t.size() == 1)
      chk_burst("post", 0, 4, 60);
    chk("post_pkt_cnt", out_rd_pkt_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
